reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4: number of sequenced reset domains, legal range >= 1.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: cycles each domain's reset is held before release, legal range >= 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum wait cycles for a domain's ready, legal range >= 1.
REQ-004 SHALL have port sync_clk, input, 1 bit: the single clock; all logic is rising-edge on sync_clk.
REQ-005 SHALL have port reset_async, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port soft_reset_req, input, 1 bit: synchronous restart request; a single-cycle pulse is sufficient.
REQ-007 SHALL have port domain_ready, input, NUM_DOMAINS bits: per-domain "out of reset and running" indication, already synchronous to sync_clk.
REQ-008 SHALL have port domain_reset, output, NUM_DOMAINS bits: per-domain active-high reset, driven directly from flops.
REQ-009 SHALL have port seq_done, output, 1 bit: high while all domains are released.
REQ-010 SHALL have port seq_error, output, 1 bit: high while in timeout error.
REQ-011 SHALL have port err_domain, output, max(1,$clog2(NUM_DOMAINS)) bits: index of the domain that timed out.

Function
REQ-012 SHALL implement states HOLD, WAIT, DONE and ERROR, plus a domain index idx, a hold counter and a timeout timer.
REQ-013 HOLD SHALL increment the hold counter each edge; on the edge where it equals HOLD_CYCLES-1, it SHALL clear domain_reset[idx], zero the timer and enter WAIT, so release occurs HOLD_CYCLES edges after HOLD entry.
REQ-014 WAIT SHALL sample only domain_ready[idx]; ready bits of all other domains are ignored.
REQ-015 WAIT, on an edge with domain_ready[idx]=1 and idx<NUM_DOMAINS-1, SHALL increment idx, zero the hold counter and enter HOLD.
REQ-016 WAIT, on an edge with domain_ready[idx]=1 and idx=NUM_DOMAINS-1, SHALL enter DONE and set seq_done=1.
REQ-017 WAIT, on an edge with domain_ready[idx]=0 and timer=TIMEOUT_CYCLES-1, SHALL enter ERROR, set seq_error=1, load err_domain=idx and reassert all domain_reset bits.
REQ-018 WAIT, on an edge with domain_ready[idx]=0 and timer<TIMEOUT_CYCLES-1, SHALL increment the timer.
REQ-019 Ready and timeout on the same edge SHALL resolve as ready (no error).
REQ-020 DONE and ERROR SHALL be sticky; domain_ready changes SHALL be ignored in both; exit is only via soft_reset_req or reset_async.
REQ-021 soft_reset_req=1 in any state SHALL, on that edge, set all domain_reset bits, clear seq_done, seq_error and err_domain, zero idx and the hold counter, and enter HOLD.
REQ-022 soft_reset_req SHALL take priority over ready, timeout and hold completion on the same edge.
REQ-023 Released domains SHALL stay released until ERROR, soft_reset_req or reset_async; domains are never released out of index order.
REQ-024 Counter widths SHALL hold HOLD_CYCLES-1 and TIMEOUT_CYCLES-1 without wrap; all compares SHALL be unsigned.

Reset
REQ-025 While reset_async=1, the block SHALL hold domain_reset all ones, seq_done=0, seq_error=0, err_domain=0, idx=0, hold counter and timer 0, and state HOLD.
REQ-026 These values SHALL be applied asynchronously; sequencing SHALL start on the first sync_clk edge after deassertion, with that edge counted as edge 1.
REQ-027 Assertion of reset_async mid-sequence, in DONE or in ERROR SHALL immediately restore the REQ-025 values.

Verification
REQ-028 Defaults, domain_ready tied all ones -> domain_reset[0..3] fall at edges 8, 17, 26, 35; seq_done rises at edge 36.
REQ-029 Defaults, domain_ready[0] never high -> domain_reset[0] falls at edge 8; at edge 264 seq_error=1, err_domain=0, domain_reset=4'b1111.
REQ-030 Defaults, domain_ready[2] rises 5 edges after domain_reset[2] falls; domain_ready[3] asserted early -> ready[3] ignored until idx=3; seq_done follows correctly.
REQ-031 soft_reset_req pulsed in DONE, and separately on the same edge as a timeout -> domain_reset=all ones, seq_done=0, seq_error=0, and the full sequence repeats from HOLD.
REQ-032 reset_async pulsed asynchronously, between clock edges, while in WAIT for idx=1 -> outputs take REQ-025 values before the next edge; the sequence restarts at domain 0.
REQ-033 NUM_DOMAINS=1, HOLD_CYCLES=1, TIMEOUT_CYCLES=1, ready low -> release at edge 1, error at edge 2, err_domain width 1.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_DOMAINS resets one at a time in index order,
// holding each for HOLD_CYCLES edges and then waiting (bounded by TIMEOUT_CYCLES) for its ready.
// No backpressure; soft_reset_req restarts on the same edge, reset_async restarts immediately.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   sync_clk,
  input  logic                   reset_async,
  input  logic                   soft_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   seq_done,
  output logic                   seq_error,
  output logic [((NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1)-1:0] err_domain
);

  localparam int IDX_W  = (NUM_DOMAINS > 1)    ? $clog2(NUM_DOMAINS)    : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1)    ? $clog2(HOLD_CYCLES)    : 1;
  localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [IDX_W-1:0]       err_dom_q, err_dom_d;

  // State and output registers; reset_async forces every domain back into reset at once.
  always_ff @(posedge sync_clk or posedge reset_async) begin
    if (reset_async) begin
      state_q   <= S_HOLD;
      idx_q     <= '0;
      hold_q    <= '0;
      timer_q   <= '0;
      rst_q     <= '1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timer_q   <= timer_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_dom_q <= err_dom_d;
    end
  end

  // Next-state logic; a soft restart overrides whatever the current state would do this edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    rst_d     = rst_q;
    done_d    = done_q;
    error_d   = error_q;
    err_dom_d = err_dom_q;

    if (soft_reset_req) begin
      state_d   = S_HOLD;
      idx_d     = '0;
      hold_d    = '0;
      timer_d   = '0;
      rst_d     = '1;
      done_d    = 1'b0;
      error_d   = 1'b0;
      err_dom_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          // Release on the last hold edge; the counter is not advanced past its final value.
          if (hold_q == HOLD_LAST) begin
            rst_d[idx_q] = 1'b0;
            timer_d      = '0;
            state_d      = S_WAIT;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_WAIT: begin
          // Ready wins over an expiring timer on the same edge.
          if (domain_ready[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              hold_d  = '0;
              state_d = S_HOLD;
            end
          end else if (timer_q == TMR_LAST) begin
            state_d   = S_ERROR;
            error_d   = 1'b1;
            err_dom_d = idx_q;
            rst_d     = '1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_DONE:  state_d = S_DONE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_HOLD;
      endcase
    end
  end

  assign domain_reset = rst_q;
  assign seq_done     = done_q;
  assign seq_error    = error_q;
  assign err_domain   = err_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a 1-domain/1-cycle instance.
module tb_reset_sequencer;

  logic       sync_clk;
  logic       reset_async;
  logic       soft_reset_req;
  logic [3:0] domain_ready;
  logic [3:0] domain_reset;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] err_domain;

  logic       rst2;
  logic       soft2;
  logic [0:0] ready2;
  logic [0:0] dreset2;
  logic       done2;
  logic       error2;
  logic [0:0] errdom2;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  reset_sequencer dut (
    .sync_clk       (sync_clk),
    .reset_async    (reset_async),
    .soft_reset_req (soft_reset_req),
    .domain_ready   (domain_ready),
    .domain_reset   (domain_reset),
    .seq_done       (seq_done),
    .seq_error      (seq_error),
    .err_domain     (err_domain)
  );

  reset_sequencer #(
    .NUM_DOMAINS    (1),
    .HOLD_CYCLES    (1),
    .TIMEOUT_CYCLES (1)
  ) dut_min (
    .sync_clk       (sync_clk),
    .reset_async    (rst2),
    .soft_reset_req (soft2),
    .domain_ready   (ready2),
    .domain_reset   (dreset2),
    .seq_done       (done2),
    .seq_error      (error2),
    .err_domain     (errdom2)
  );

  initial sync_clk = 1'b0;
  always #5 sync_clk = ~sync_clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge sync_clk);
    #1;
    edge_n++;
  endtask

  // Assert reset mid-cycle, then drop it between edges so the next edge is edge 1.
  task automatic restart(input logic [3:0] rdy);
    @(negedge sync_clk);
    reset_async = 1'b1;
    domain_ready = rdy;
    #2;
    reset_async = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    reset_async = 1'b1; soft_reset_req = 1'b0; domain_ready = 4'h0;
    tick(); tick();
    total++;
    if (domain_reset !== 4'b1111 || seq_done !== 1'b0 || seq_error !== 1'b0 || err_domain !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got rst=%b done=%b err=%b dom=%0d want rst=1111 done=0 err=0 dom=0",
               domain_reset, seq_done, seq_error, err_domain);
    end
  endtask

  task automatic test_all_ready();
    logic [3:0] exp_rst;
    logic       exp_done;
    restart(4'hF);
    for (int e = 1; e <= 40; e++) begin
      tick();
      exp_rst  = {edge_n < 35, edge_n < 26, edge_n < 17, edge_n < 8};
      exp_done = (edge_n >= 36);
      total++;
      if (domain_reset !== exp_rst || seq_done !== exp_done || seq_error !== 1'b0) begin
        bad++;
        $display("FAIL all_ready edge=%0d got rst=%b done=%b err=%b want rst=%b done=%b err=0",
                 edge_n, domain_reset, seq_done, seq_error, exp_rst, exp_done);
      end
    end
    // DONE must ignore ready dropping away.
    domain_ready = 4'h0;
    for (int e = 0; e < 5; e++) tick();
    total++;
    if (seq_done !== 1'b1 || domain_reset !== 4'b0000) begin
      bad++;
      $display("FAIL done_sticky got rst=%b done=%b want rst=0000 done=1", domain_reset, seq_done);
    end
    domain_ready = 4'hF;
  endtask

  task automatic test_soft_in_done();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    edge_n = 0;
    total++;
    if (domain_reset !== 4'b1111 || seq_done !== 1'b0 || seq_error !== 1'b0) begin
      bad++;
      $display("FAIL soft_done_edge got rst=%b done=%b err=%b want rst=1111 done=0 err=0",
               domain_reset, seq_done, seq_error);
    end
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (edge_n == 7) begin
        total++;
        if (domain_reset !== 4'b1111) begin
          bad++; $display("FAIL soft_done_e7 got rst=%b want rst=1111", domain_reset);
        end
      end
      if (edge_n == 8) begin
        total++;
        if (domain_reset !== 4'b1110) begin
          bad++; $display("FAIL soft_done_e8 got rst=%b want rst=1110", domain_reset);
        end
      end
      if (edge_n == 35) begin
        total++;
        if (domain_reset !== 4'b0000 || seq_done !== 1'b0) begin
          bad++; $display("FAIL soft_done_e35 got rst=%b done=%b want rst=0000 done=0", domain_reset, seq_done);
        end
      end
      if (edge_n == 36) begin
        total++;
        if (seq_done !== 1'b1) begin
          bad++; $display("FAIL soft_done_e36 got done=%b want done=1", seq_done);
        end
      end
    end
  endtask

  task automatic test_out_of_order();
    restart(4'b1011);
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (edge_n == 25 && domain_reset !== 4'b1100) begin
        bad++; $display("FAIL ooo_e25 got rst=%b want rst=1100", domain_reset);
      end
      if (edge_n == 25) total++;
      if (edge_n == 30 || edge_n == 31 || edge_n == 38) begin
        total++;
        if (domain_reset !== 4'b1000 || seq_done !== 1'b0) begin
          bad++; $display("FAIL ooo_e%0d got rst=%b done=%b want rst=1000 done=0", edge_n, domain_reset, seq_done);
        end
      end
      if (edge_n == 39) begin
        total++;
        if (domain_reset !== 4'b0000 || seq_done !== 1'b0) begin
          bad++; $display("FAIL ooo_e39 got rst=%b done=%b want rst=0000 done=0", domain_reset, seq_done);
        end
      end
      if (edge_n == 40) begin
        total++;
        if (seq_done !== 1'b1) begin
          bad++; $display("FAIL ooo_e40 got done=%b want done=1", seq_done);
        end
      end
      // Domain 2 becomes ready so that edge 31 is the first edge sampling it high.
      if (edge_n == 30) domain_ready = 4'b1111;
    end
  endtask

  task automatic test_timeout_d0();
    restart(4'b0000);
    for (int e = 1; e <= 264; e++) begin
      tick();
      if (edge_n == 8 || edge_n == 263) begin
        total++;
        if (domain_reset !== 4'b1110 || seq_error !== 1'b0) begin
          bad++; $display("FAIL to0_e%0d got rst=%b err=%b want rst=1110 err=0", edge_n, domain_reset, seq_error);
        end
      end
    end
    total++;
    if (domain_reset !== 4'b1111 || seq_error !== 1'b1 || err_domain !== 2'd0 || seq_done !== 1'b0) begin
      bad++;
      $display("FAIL to0_e264 got rst=%b err=%b dom=%0d done=%b want rst=1111 err=1 dom=0 done=0",
               domain_reset, seq_error, err_domain, seq_done);
    end
    domain_ready = 4'hF;
    for (int e = 0; e < 10; e++) tick();
    total++;
    if (seq_error !== 1'b1 || domain_reset !== 4'b1111 || seq_done !== 1'b0) begin
      bad++; $display("FAIL err_sticky got rst=%b err=%b done=%b want rst=1111 err=1 done=0",
                      domain_reset, seq_error, seq_done);
    end
  endtask

  task automatic test_soft_on_timeout();
    restart(4'b0000);
    for (int e = 1; e <= 263; e++) tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    total++;
    if (domain_reset !== 4'b1111 || seq_error !== 1'b0 || seq_done !== 1'b0) begin
      bad++; $display("FAIL soft_vs_timeout got rst=%b err=%b done=%b want rst=1111 err=0 done=0",
                      domain_reset, seq_error, seq_done);
    end
    edge_n = 0;
    for (int e = 1; e <= 8; e++) tick();
    total++;
    if (domain_reset !== 4'b1110 || seq_error !== 1'b0) begin
      bad++; $display("FAIL soft_vs_timeout_rel got rst=%b err=%b want rst=1110 err=0", domain_reset, seq_error);
    end
  endtask

  task automatic test_timeout_idx2();
    restart(4'b0011);
    for (int e = 1; e <= 282; e++) begin
      tick();
      if (edge_n == 26 || edge_n == 281) begin
        total++;
        if (domain_reset !== 4'b1000 || seq_error !== 1'b0) begin
          bad++; $display("FAIL to2_e%0d got rst=%b err=%b want rst=1000 err=0", edge_n, domain_reset, seq_error);
        end
      end
    end
    total++;
    if (domain_reset !== 4'b1111 || seq_error !== 1'b1 || err_domain !== 2'd2) begin
      bad++; $display("FAIL to2_e282 got rst=%b err=%b dom=%0d want rst=1111 err=1 dom=2",
                      domain_reset, seq_error, err_domain);
    end
    // Asynchronous reset out of ERROR, checked before any further edge.
    @(negedge sync_clk);
    #1;
    reset_async = 1'b1;
    #1;
    total++;
    if (domain_reset !== 4'b1111 || seq_error !== 1'b0 || err_domain !== 2'd0 || seq_done !== 1'b0) begin
      bad++; $display("FAIL arst_in_error got rst=%b err=%b dom=%0d done=%b want rst=1111 err=0 dom=0 done=0",
                      domain_reset, seq_error, err_domain, seq_done);
    end
  endtask

  task automatic test_async_reset_wait1();
    restart(4'b0001);
    for (int e = 1; e <= 20; e++) tick();
    total++;
    if (domain_reset !== 4'b1100) begin
      bad++; $display("FAIL wait1_pre got rst=%b want rst=1100", domain_reset);
    end
    #2;
    reset_async = 1'b1;
    #1;
    total++;
    if (domain_reset !== 4'b1111 || seq_done !== 1'b0 || seq_error !== 1'b0 || err_domain !== 2'd0) begin
      bad++; $display("FAIL wait1_arst got rst=%b done=%b err=%b dom=%0d want rst=1111 done=0 err=0 dom=0",
                      domain_reset, seq_done, seq_error, err_domain);
    end
    #1;
    reset_async = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (edge_n == 7) begin
        total++;
        if (domain_reset !== 4'b1111) begin
          bad++; $display("FAIL wait1_e7 got rst=%b want rst=1111", domain_reset);
        end
      end
    end
    total++;
    if (domain_reset !== 4'b1110) begin
      bad++; $display("FAIL wait1_e8 got rst=%b want rst=1110", domain_reset);
    end
  endtask

  task automatic test_min_config();
    ready2 = 1'b0;
    soft2  = 1'b0;
    #1;
    total++;
    if (dreset2 !== 1'b1 || error2 !== 1'b0 || errdom2 !== 1'b0 || done2 !== 1'b0) begin
      bad++; $display("FAIL min_reset got rst=%b err=%b dom=%b done=%b want rst=1 err=0 dom=0 done=0",
                      dreset2, error2, errdom2, done2);
    end
    @(negedge sync_clk);
    rst2 = 1'b0;
    tick();
    total++;
    if (dreset2 !== 1'b0 || error2 !== 1'b0) begin
      bad++; $display("FAIL min_e1 got rst=%b err=%b want rst=0 err=0", dreset2, error2);
    end
    tick();
    total++;
    if (dreset2 !== 1'b1 || error2 !== 1'b1 || errdom2 !== 1'b0) begin
      bad++; $display("FAIL min_e2 got rst=%b err=%b dom=%b want rst=1 err=1 dom=0", dreset2, error2, errdom2);
    end
    soft2 = 1'b1;
    tick();
    soft2 = 1'b0;
    total++;
    if (dreset2 !== 1'b1 || error2 !== 1'b0) begin
      bad++; $display("FAIL min_soft got rst=%b err=%b want rst=1 err=0", dreset2, error2);
    end
    tick();
    total++;
    if (dreset2 !== 1'b0 || error2 !== 1'b0) begin
      bad++; $display("FAIL min_rerelease got rst=%b err=%b want rst=0 err=0", dreset2, error2);
    end
  endtask

  initial begin
    reset_async = 1'b1;
    soft_reset_req = 1'b0;
    domain_ready = 4'h0;
    rst2 = 1'b1;
    soft2 = 1'b0;
    ready2 = 1'b0;
    test_reset();
    test_all_ready();
    test_soft_in_done();
    test_out_of_order();
    test_timeout_d0();
    test_soft_on_timeout();
    test_timeout_idx2();
    test_async_reset_wait1();
    test_min_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
